// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//   Instruction-fetch stage for the single-cycle CPU. It owns the PC, fetches
//   from a variable-latency instruction memory over a req/ack handshake, and
//   holds the fetched word for the control unit and datapath until retirement.
//   On retirement it computes the next PC from Branch/Zero/Jump and starts the
//   next fetch.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   imem_req/imem_addr  fetch request (held until ack) and byte address (= pc)
//   imem_ack/imem_rdata memory response; rdata sampled only on accepted ack
//   retire              datapath finished the current instruction
//   Branch/Zero/Jump    next-PC selection inputs, valid with retire
//   instr/instr_valid   held instruction word and its valid flag
//   Op/Fuc              instr[31:26] / instr[5:0]
//   pc/pc_plus4         current PC and pc + 4
//   retired_cnt         count of retired instructions (wraps)
// ---------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             retire,
  input  logic             Branch,
  input  logic             Zero,
  input  logic             Jump,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [5:0]       Op,
  output logic [5:0]       Fuc,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             instr_valid_q, instr_valid_d;
  logic             imem_req_q, imem_req_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

  logic [31:0]      branch_off;
  logic [31:0]      next_pc;

  assign pc_plus4   = pc_q + 32'd4;
  // Word offset: sign-extended 16-bit immediate scaled by 4.
  assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Jump takes priority over a taken branch.
  always_comb begin
    next_pc = pc_plus4;
    if (Jump) begin
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (Branch && Zero) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    imem_req_d    = imem_req_q;
    retired_cnt_d = retired_cnt_q;

    case (state_q)
      BOOT: begin
        state_d    = FETCH;
        imem_req_d = 1'b1;
      end
      FETCH: begin
        // Gating on the registered request keeps stale acks from being taken.
        if (imem_ack && imem_req_q) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
          state_d       = EXEC;
        end
      end
      EXEC: begin
        if (retire) begin
          pc_d          = next_pc;
          retired_cnt_d = retired_cnt_q + CNT_W'(1);
          instr_valid_d = 1'b0;
          imem_req_d    = 1'b1;
          state_d       = FETCH;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      retired_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign Op          = instr_q[31:26];
  assign Fuc         = instr_q[5:0];
  assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//   Scoreboard bench for inst_fetch. The driver plays the instruction memory
//   and the datapath, predicting each fetch address / retired count and each
//   delivered instruction with a plain arithmetic PC model; the monitor pops
//   those predictions when the DUT starts a fetch or raises instr_valid.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int unsigned CW     = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          retire = 1'b0;
  logic          Branch = 1'b0;
  logic          Zero = 1'b0;
  logic          Jump = 1'b0;
  logic [31:0]   instr;
  logic          instr_valid;
  logic [5:0]    Op;
  logic [5:0]    Fuc;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic [CW-1:0] retired_cnt;

  inst_fetch #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .retire(retire), .Branch(Branch), .Zero(Zero), .Jump(Jump),
    .instr(instr), .instr_valid(instr_valid), .Op(Op), .Fuc(Fuc),
    .pc(pc), .pc_plus4(pc_plus4), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; int unsigned cnt; } fetch_t;
  typedef struct { logic [31:0] w;  logic [31:0] pc;  } instr_t;

  fetch_t      exp_fetch[$];
  instr_t      exp_instr[$];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [31:0] m_pc;
  int unsigned m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Next PC from the architectural rules: jump region, word-offset branch, else sequential.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                             input bit br, input bit zr, input bit jp);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    if (jp) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (br && zr) begin
      off = int'($signed(w[15:0]));
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  function automatic logic [31:0] cnt_exp(input int unsigned c);
    return 32'(c % (1 << CW));
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    bit          req_prev = 0;
    bit          iv_prev  = 0;
    logic [31:0] cur_fpc  = '0;
    logic [31:0] cur_w    = '0;
    logic [31:0] cur_ipc  = '0;
    fetch_t      f;
    instr_t      e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        req_prev = 0;
        iv_prev  = 0;
      end else begin
        if (imem_req && !req_prev) begin
          if (exp_fetch.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL fetch_unexpected: got addr %h expected no fetch", imem_addr);
          end else begin
            f = exp_fetch.pop_front();
            cur_fpc = f.pc;
            chk("fetch_addr", imem_addr, f.pc);
            chk("fetch_pc", pc, f.pc);
            chk("pc_plus4", pc_plus4, f.pc + 32'd4);
            chk("retired_cnt", 32'(retired_cnt), cnt_exp(f.cnt));
          end
        end else if (imem_req) begin
          chk("fetch_addr_stable", imem_addr, cur_fpc);
          chk("fetch_valid_low", 32'(instr_valid), 32'd0);
        end
        if (instr_valid && !iv_prev) begin
          if (exp_instr.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL instr_unexpected: got instr %h expected none", instr);
          end else begin
            e = exp_instr.pop_front();
            cur_w = e.w; cur_ipc = e.pc;
            chk("instr", instr, e.w);
            chk("op", 32'(Op), e.w >> 26);
            chk("fuc", 32'(Fuc), e.w & 32'h3F);
            chk("exec_pc", pc, e.pc);
          end
        end else if (instr_valid) begin
          chk("instr_hold", instr, cur_w);
          chk("exec_pc_hold", pc, cur_ipc);
        end
        req_prev = imem_req;
        iv_prev  = instr_valid;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_reset(input bit late_ack);
    fetch_t f;
    @(posedge clk);
    #2;
    rst = 1'b0; retire = 1'b0; imem_ack = 1'b0;
    #1;
    chk("rst_pc", pc, RST_PC);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_cnt", 32'(retired_cnt), 32'd0);
    chk("rst_opfuc", {20'd0, Op, Fuc}, 32'd0);
    exp_fetch.delete();
    exp_instr.delete();
    m_pc = RST_PC; m_cnt = 0;
    f.pc = m_pc; f.cnt = m_cnt;
    exp_fetch.push_back(f);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    if (late_ack) begin
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    imem_ack = 1'b0;
    chk("boot_valid", 32'(instr_valid), 32'd0);
    chk("boot_instr", instr, 32'd0);
    chk("boot_req", 32'(imem_req), 32'd1);
  endtask

  // abort: 0 none, 1 reset while fetching, 2 reset while executing
  task automatic do_instr(input logic [31:0] w, input int d, input int ex,
                          input bit br, input bit zr, input bit jp,
                          input bit spur, input int abort);
    int     t;
    instr_t e;
    fetch_t f;
    t = 0;
    while (!imem_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!imem_req) begin
      n_chk++; n_fail++;
      $display("FAIL req_timeout: got imem_req 0 expected 1 within 50 cycles");
      return;
    end
    for (int i = 0; i < d; i++) begin
      imem_ack   = 1'b0;
      retire     = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      Jump       = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(negedge clk);
    end
    retire = 1'b0;
    if (abort == 1) begin
      do_reset(1);
      return;
    end
    imem_ack = 1'b1; imem_rdata = w;
    e.w = w; e.pc = m_pc;
    exp_instr.push_back(e);
    @(negedge clk);
    for (int i = 0; i < ex; i++) begin
      imem_ack   = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    if (abort == 2) begin
      do_reset(1);
      return;
    end
    retire = 1'b1; Branch = br; Zero = zr; Jump = jp;
    m_pc  = model_next(m_pc, w, br, zr, jp);
    m_cnt = m_cnt + 1;
    f.pc = m_pc; f.cnt = m_cnt;
    exp_fetch.push_back(f);
    @(negedge clk);
    retire = 1'b0;
    Branch = 1'($urandom_range(0, 1));
    Zero   = 1'($urandom_range(0, 1));
    Jump   = 1'($urandom_range(0, 1));
  endtask

  initial begin : driver
    logic [31:0] w;
    do_reset(0);
    // first instruction, 1-cycle ack latency: pc 3000 -> 3004
    do_instr(32'h2008_0005, 1, 1, 0, 0, 0, 0, 0);
    repeat (3) do_instr($urandom & 32'h0000_7FFF, 0, 0, 0, 0, 0, 0, 0);   // to 3010
    do_instr(32'h1000_FFFE, 1, 1, 1, 1, 0, 0, 0);                         // -> 300C
    do_instr(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0);                         // -> 3010
    do_instr(32'h1000_FFFE, 2, 0, 1, 0, 0, 0, 0);                         // not taken -> 3014
    repeat (3) do_instr(32'h0000_0020, 0, 1, 0, 0, 0, 0, 0);              // to 3020
    do_instr(32'h0800_0C10, 1, 2, 1, 1, 1, 0, 0);                         // jump wins -> 3040
    do_instr(32'h0000_0025, 5, 2, 0, 0, 0, 1, 0);                         // 5-cycle wait, spurious retires
    do_instr(32'h0000_0020, 3, 0, 0, 0, 0, 0, 1);                         // reset mid-fetch
    do_instr(32'h2008_0005, 1, 3, 0, 0, 0, 0, 2);                         // reset mid-exec
    // 17 retirements wrap the 4-bit counter to 1
    repeat (17) do_instr($urandom & 32'h03FF_7FFF, $urandom_range(0, 2), $urandom_range(0, 2),
                         0, 0, 0, 1, 0);
    // jump to 0, then branch back by one word -> FFFF_FFFC, then wrap to 0
    do_instr(32'h0800_0000, 1, 0, 0, 0, 1, 0, 0);
    do_instr(32'h1000_FFFE, 1, 0, 1, 1, 0, 0, 0);
    do_instr(32'h0000_0020, 1, 0, 0, 0, 0, 0, 0);
    do_instr(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      w = $urandom;
      do_instr(w, $urandom_range(0, 4), $urandom_range(0, 3),
               ($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) < 2), 1, 0);
    end
    repeat (4) @(negedge clk);
    chk("fetch_queue_drained", 32'(exp_fetch.size()), 32'd0);
    chk("instr_queue_drained", 32'(exp_instr.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "simulation time limit reached");
  end

endmodule
